// File: rtl/uart_ctrl_pkg.sv
// Shared types and defaults for the two-requester UART transmit scheduler.
package uart_ctrl_pkg;

   localparam int unsigned DATA_W          = 8;
   localparam int unsigned BAUD_W          = 3;
   localparam int unsigned CNT_W           = 16;
   localparam int unsigned DEF_FIFO_DEPTH  = 4;
   localparam int unsigned DEF_ACK_TIMEOUT = 7;

   localparam logic [BAUD_W-1:0] BAUD_RESET = 3'd7;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE
   } state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO; a pushed byte is visible on dout from the next cycle.
module uart_byte_fifo
   import uart_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] din,
   input  logic              push,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              do_push;
   logic              do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // Storage needs no reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between two byte requesters,
// with between-byte baud updates, ack timeout detection and a sent-byte counter.
module uart_tx_scheduler
   import uart_ctrl_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req1_data,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              enable,
   input  logic [BAUD_W-1:0] cfg_baud,
   input  logic              cfg_we,
   output logic [BAUD_W-1:0] baud_select,
   output logic [DATA_W-1:0] Tx_DATA,
   output logic              Tx_WR,
   output logic              Tx_EN,
   input  logic              Tx_BUSY,
   output logic [CNT_W-1:0]  sent_count,
   output logic              err_timeout
);

   localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

   state_t            state, state_nxt;
   logic [DATA_W-1:0] dout0, dout1;
   logic              full0, full1, empty0, empty1;
   logic              pop0, pop1;
   logic              grant, grant_sel;
   logic              apply_baud, timeout_hit, byte_done;
   logic              last_grant;
   logic              pending_valid;
   logic [BAUD_W-1:0] pending_baud;
   logic [TW-1:0]     ack_cnt;

   assign req0_ready = ~full0;
   assign req1_ready = ~full1;

   uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
      .clk(clk), .reset(reset), .din(req0_data), .push(req0_valid), .pop(pop0),
      .dout(dout0), .full(full0), .empty(empty0)
   );

   uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
      .clk(clk), .reset(reset), .din(req1_data), .push(req1_valid), .pop(pop1),
      .dout(dout1), .full(full1), .empty(empty1)
   );

   // Next state, arbitration and per-cycle event strobes.
   always_comb begin
      state_nxt   = state;
      grant       = 1'b0;
      grant_sel   = 1'b0;
      pop0        = 1'b0;
      pop1        = 1'b0;
      apply_baud  = 1'b0;
      timeout_hit = 1'b0;
      byte_done   = 1'b0;
      case (state)
         IDLE: begin
            if (pending_valid) begin
               apply_baud = 1'b1;
            end else if (enable && !Tx_BUSY && (!empty0 || !empty1)) begin
               grant     = 1'b1;
               grant_sel = (!empty0 && !empty1) ? ~last_grant : empty0;
               pop0      = ~grant_sel;
               pop1      = grant_sel;
               state_nxt = ISSUE;
            end
         end
         ISSUE: state_nxt = WAIT_ACK;
         WAIT_ACK: begin
            if (Tx_BUSY) begin
               state_nxt = WAIT_DONE;
            end else if (ack_cnt == TW'(ACK_TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               state_nxt   = IDLE;
            end
         end
         WAIT_DONE: begin
            if (!Tx_BUSY) begin
               byte_done = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         Tx_DATA       <= '0;
         Tx_WR         <= 1'b0;
         Tx_EN         <= 1'b0;
         baud_select   <= BAUD_RESET;
         sent_count    <= '0;
         err_timeout   <= 1'b0;
         last_grant    <= 1'b1;
         pending_valid <= 1'b0;
         pending_baud  <= BAUD_RESET;
         ack_cnt       <= '0;
      end else begin
         state <= state_nxt;
         Tx_WR <= (state_nxt == ISSUE);
         Tx_EN <= enable | (state != IDLE);
         if (grant) begin
            Tx_DATA    <= grant_sel ? dout1 : dout0;
            last_grant <= grant_sel;
         end
         if (apply_baud) baud_select <= pending_baud;
         // A new write wins over the clear that happens when the old value is applied.
         if (cfg_we) begin
            pending_valid <= 1'b1;
            pending_baud  <= cfg_baud;
         end else if (apply_baud) begin
            pending_valid <= 1'b0;
         end
         if (state == ISSUE)                                  ack_cnt <= '0;
         else if (state == WAIT_ACK && !Tx_BUSY && !timeout_hit) ack_cnt <= ack_cnt + TW'(1);
         if (timeout_hit) err_timeout <= 1'b1;
         if (byte_done)   sent_count  <= sent_count + CNT_W'(1);
      end
   end

endmodule
